// File: rtl/ps2_tx_scheduler_if.sv
// ps2_tx_scheduler_if
// Groups the key-code input, the secondary message handshake, the uart_tx
// drive signals and the status outputs of ps2_tx_scheduler.
//   i_code / i_code_valid     key code strobe from ps2_interpreter
//   i_msg_data / i_msg_valid  secondary byte request (held until accepted)
//   o_msg_ready               secondary byte accepted when valid && ready
//   o_tx_data / o_tx_send     byte and one-cycle send strobe to uart_tx
//   o_busy, o_fifo_count      activity and FIFO occupancy
//   o_overflow/i_clr_overflow sticky key-code drop flag and its clear
// master: the side that drives requests; slave: the scheduler.
interface ps2_tx_scheduler_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    i_code;
    logic          i_code_valid;
    logic [7:0]    i_msg_data;
    logic          i_msg_valid;
    logic          o_msg_ready;
    logic [7:0]    o_tx_data;
    logic          o_tx_send;
    logic          o_busy;
    logic [CW-1:0] o_fifo_count;
    logic          o_overflow;
    logic          i_clr_overflow;

    modport master (
        output i_code, i_code_valid, i_msg_data, i_msg_valid, i_clr_overflow,
        input  o_msg_ready, o_tx_data, o_tx_send, o_busy, o_fifo_count, o_overflow
    );

    modport slave (
        input  i_code, i_code_valid, i_msg_data, i_msg_valid, i_clr_overflow,
        output o_msg_ready, o_tx_data, o_tx_send, o_busy, o_fifo_count, o_overflow
    );
endinterface

// File: rtl/ps2_tx_scheduler.sv
// ps2_tx_scheduler
// Buffers key codes in a circular FIFO and arbitrates uart_tx between the
// key-code stream and a secondary message requester. uart_tx has no busy
// output, so every frame is self-timed with a down-counter before the next
// send strobe is allowed.
// Ports:
//   i_clk  system clock
//   i_rst  asynchronous reset, active-high
//   bus    ps2_tx_scheduler_if.slave (code/msg inputs, tx outputs, status)
//
// state  | meaning
// IDLE   | line free; launch FIFO head or secondary byte if one is granted
// LAUNCH | o_tx_send is high this cycle; load frame timer
// WAIT   | frame (plus gap) in flight; count down to zero
module ps2_tx_scheduler #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FRAME_BITS   = 10,
    parameter int GAP_CLKS     = 2,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    ps2_tx_scheduler_if.slave    bus
);
    localparam int T_WAIT = CLKS_PER_BIT * FRAME_BITS + GAP_CLKS;
    localparam int CNT_W  = $clog2(T_WAIT + 1);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = AW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT} state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_send_q, tx_send_d;
    logic            overflow_q, overflow_d;
    logic            last_msg_q, last_msg_d;   // 1: last grant went to the secondary requester
    logic [7:0]      mem [FIFO_DEPTH];

    logic fifo_empty, fifo_full, fifo_grant, msg_ready, msg_take;
    logic push_ok, drop;

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CW'(FIFO_DEPTH));
        // Grant depends on state, occupancy and pointer only, so o_msg_ready
        // never combinationally depends on i_msg_valid.
        fifo_grant = (state_q == ST_IDLE) && !fifo_empty && (last_msg_q || !bus.i_msg_valid);
        msg_ready  = (state_q == ST_IDLE) && (fifo_empty || !last_msg_q);
        msg_take   = bus.i_msg_valid && msg_ready && !fifo_grant;
        // A pop in the same cycle frees the slot, so a push at full still lands.
        push_ok    = bus.i_code_valid && (!fifo_full || fifo_grant);
        drop       = bus.i_code_valid && fifo_full && !fifo_grant;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        tx_send_d  = 1'b0;
        last_msg_d = last_msg_q;
        case (state_q)
            ST_IDLE: begin
                if (fifo_grant) begin
                    tx_data_d  = mem[rd_ptr_q];
                    tx_send_d  = 1'b1;
                    last_msg_d = 1'b0;
                    state_d    = ST_LAUNCH;
                end else if (msg_take) begin
                    tx_data_d  = bus.i_msg_data;
                    tx_send_d  = 1'b1;
                    last_msg_d = 1'b1;
                    state_d    = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                cnt_d   = CNT_W'(T_WAIT - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_WAIT;
                cnt_d   = CNT_W'(T_WAIT);
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (fifo_grant) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, fifo_grant})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Set wins over clear so a drop coincident with a clear is not lost.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (bus.i_clr_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_WAIT;
            cnt_q      <= CNT_W'(T_WAIT);
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_data_q  <= '0;
            tx_send_q  <= 1'b0;
            overflow_q <= 1'b0;
            last_msg_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_data_q  <= tx_data_d;
            tx_send_q  <= tx_send_d;
            overflow_q <= overflow_d;
            last_msg_q <= last_msg_d;
        end
    end

    // Storage needs no reset; occupancy and pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr_q] <= bus.i_code;
    end

    assign bus.o_msg_ready  = msg_ready;
    assign bus.o_tx_data    = tx_data_q;
    assign bus.o_tx_send    = tx_send_q;
    assign bus.o_busy       = (state_q != ST_IDLE) || !fifo_empty;
    assign bus.o_fifo_count = count_q;
    assign bus.o_overflow   = overflow_q;
endmodule
